// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: finds symbol alignment from runs of control tokens,
// then classifies each aligned symbol (control / TERC4 / video) and decodes it.
module tmds_channel_decoder #(
   parameter int LOCK_COUNT = 8,
   parameter int DWELL      = 4096
) (
   input  logic       clk_pixel,
   input  logic       reset,
   input  logic [9:0] tmds_in,
   output logic       locked,
   output logic [3:0] bit_offset,
   output logic       ctrl_valid,
   output logic [1:0] ctrl,
   output logic       terc4_valid,
   output logic [3:0] terc4,
   output logic       video_valid,
   output logic [7:0] data
);

   localparam int RW = $clog2(LOCK_COUNT + 1);
   localparam int DW = $clog2(DWELL);
   localparam logic [RW-1:0] RUN_FULL  = RW'(LOCK_COUNT);
   localparam logic [DW-1:0] DWELL_END = DW'(DWELL - 1);

   typedef enum logic [0:0] {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

   function automatic logic [2:0] ctrl_lookup(input logic [9:0] q);
      logic [2:0] r;
      case (q)
         10'b1101010100: r = 3'b100;
         10'b0010101011: r = 3'b101;
         10'b0101010100: r = 3'b110;
         10'b1010101011: r = 3'b111;
         default:        r = 3'b000;
      endcase
      return r;
   endfunction

   function automatic logic [4:0] terc4_lookup(input logic [9:0] q);
      logic [4:0] r;
      case (q)
         10'b1010011100: r = 5'h10;
         10'b1001100011: r = 5'h11;
         10'b1011100100: r = 5'h12;
         10'b1011100010: r = 5'h13;
         10'b0101110001: r = 5'h14;
         10'b0100011110: r = 5'h15;
         10'b0110001110: r = 5'h16;
         10'b0100111100: r = 5'h17;
         10'b1011001100: r = 5'h18;
         10'b0100111001: r = 5'h19;
         10'b0110011100: r = 5'h1A;
         10'b1011000110: r = 5'h1B;
         10'b1010001110: r = 5'h1C;
         10'b1001110001: r = 5'h1D;
         10'b0101100011: r = 5'h1E;
         10'b1011000011: r = 5'h1F;
         default:        r = 5'h00;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] video_decode(input logic [9:0] q);
      logic [7:0] d;
      logic [7:0] r;
      d    = q[9] ? ~q[7:0] : q[7:0];
      r[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         r[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
      return r;
   endfunction

   logic [9:0]    prev_r;
   logic [19:0]   window_s;
   logic [19:0]   shifted_s;
   logic [9:0]    q_s;
   logic [2:0]    ctrl_s;
   logic [4:0]    terc_s;
   logic [7:0]    data_s;

   state_t        state_r, state_nx;
   logic [3:0]    offset_r, offset_nx, offset_adv_s;
   logic [RW-1:0] run_cnt_r, run_nx;
   logic [DW-1:0] dwell_cnt_r, dwell_nx;
   logic          run_full_s, dwell_end_s;
   logic          locked_r, ctrl_valid_r, terc4_valid_r, video_valid_r;
   logic [1:0]    ctrl_r;
   logic [3:0]    terc4_r;
   logic [7:0]    data_r;

   assign window_s  = {tmds_in, prev_r};
   assign shifted_s = window_s >> offset_r;
   assign q_s       = shifted_s[9:0];
   assign ctrl_s    = ctrl_lookup(q_s);
   assign terc_s    = terc4_lookup(q_s);
   assign data_s    = ctrl_s[2] ? 8'h00 : video_decode(q_s);

   // Stage 2: previous word plus registered classification and decode of q.
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         prev_r        <= 10'd0;
         ctrl_valid_r  <= 1'b0;
         ctrl_r        <= 2'd0;
         terc4_valid_r <= 1'b0;
         terc4_r       <= 4'd0;
         video_valid_r <= 1'b0;
         data_r        <= 8'h00;
      end else begin
         prev_r        <= tmds_in;
         ctrl_valid_r  <= ctrl_s[2];
         ctrl_r        <= ctrl_s[1:0];
         terc4_valid_r <= terc_s[4];
         terc4_r       <= terc_s[3:0];
         video_valid_r <= ~ctrl_s[2];
         data_r        <= data_s;
      end
   end

   // Alignment hunt: run completion beats dwell expiry; LOCKED times out to SEARCH.
   always_comb begin
      state_nx     = state_r;
      offset_nx    = offset_r;
      offset_adv_s = (offset_r == 4'd9) ? 4'd0 : offset_r + 4'd1;
      run_full_s   = (run_cnt_r == RUN_FULL);
      dwell_end_s  = (dwell_cnt_r == DWELL_END);
      dwell_nx     = dwell_cnt_r + DW'(1);
      case (state_r)
         SEARCH: begin
            if (run_full_s) begin
               state_nx = LOCKED;
               dwell_nx = {DW{1'b0}};
            end else if (dwell_end_s) begin
               offset_nx = offset_adv_s;
               dwell_nx  = {DW{1'b0}};
            end else begin
               state_nx = SEARCH;
            end
         end
         LOCKED: begin
            if (run_full_s) begin
               dwell_nx = {DW{1'b0}};
            end else if (dwell_end_s) begin
               state_nx  = SEARCH;
               offset_nx = offset_adv_s;
               dwell_nx  = {DW{1'b0}};
            end else begin
               state_nx = LOCKED;
            end
         end
         default: begin
            state_nx = SEARCH;
            dwell_nx = {DW{1'b0}};
         end
      endcase
      if (offset_nx != offset_r) begin
         run_nx = {RW{1'b0}};
      end else if (ctrl_valid_r) begin
         run_nx = run_full_s ? run_cnt_r : run_cnt_r + RW'(1);
      end else begin
         run_nx = {RW{1'b0}};
      end
   end

   // Alignment state, offset and counters.
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         state_r     <= SEARCH;
         offset_r    <= 4'd0;
         run_cnt_r   <= {RW{1'b0}};
         dwell_cnt_r <= {DW{1'b0}};
         locked_r    <= 1'b0;
      end else begin
         state_r     <= state_nx;
         offset_r    <= offset_nx;
         run_cnt_r   <= run_nx;
         dwell_cnt_r <= dwell_nx;
         locked_r    <= (state_nx == LOCKED);
      end
   end

   assign locked      = locked_r;
   assign bit_offset  = offset_r;
   assign ctrl_valid  = ctrl_valid_r;
   assign ctrl        = ctrl_r;
   assign terc4_valid = terc4_valid_r;
   assign terc4       = terc4_r;
   assign video_valid = video_valid_r;
   assign data        = data_r;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: serial-stream stimulus, reference decoder
// driven scoreboard, plus lock/offset/timeout observations.
module tb_tmds_channel_decoder;

   localparam int LOCK_COUNT = 8;
   localparam int DWELL      = 256;
   localparam logic [9:0] T00   = 10'b1101010100;
   localparam logic [9:0] T01   = 10'b0010101011;
   localparam logic [9:0] T10   = 10'b0101010100;
   localparam logic [9:0] T11   = 10'b1010101011;
   localparam logic [9:0] V00   = 10'b0100000000;
   localparam logic [9:0] VFF   = 10'b1000000000;
   localparam logic [9:0] TERC9 = 10'b0100111001;

   logic       clk_pixel = 1'b0;
   logic       reset     = 1'b1;
   logic [9:0] tmds_in   = 10'd0;
   logic       locked, ctrl_valid, terc4_valid, video_valid;
   logic [3:0] bit_offset, terc4;
   logic [1:0] ctrl;
   logic [7:0] data;

   tmds_channel_decoder #(.LOCK_COUNT(LOCK_COUNT), .DWELL(DWELL)) dut (
      .clk_pixel(clk_pixel), .reset(reset), .tmds_in(tmds_in),
      .locked(locked), .bit_offset(bit_offset),
      .ctrl_valid(ctrl_valid), .ctrl(ctrl),
      .terc4_valid(terc4_valid), .terc4(terc4),
      .video_valid(video_valid), .data(data)
   );

   always #5 clk_pixel = ~clk_pixel;

   int cyc = 0;
   always @(posedge clk_pixel) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [9:0] tok_tab [4]   = '{T00, T01, T10, T11};
   logic [9:0] terc_tab [16] = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                                 10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                                 10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                                 10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

   // Transmit-side 8b->10b video mapping for a given xor/xnor and invert choice.
   function automatic logic [9:0] tmds_encode(input logic [7:0] b, input logic x, input logic inv);
      logic [7:0] qm;
      qm[0] = b[0];
      for (int i = 1; i < 8; i++) qm[i] = x ? (qm[i-1] ^ b[i]) : ~(qm[i-1] ^ b[i]);
      return {inv, x, inv ? ~qm : qm};
   endfunction

   function automatic logic is_token(input logic [9:0] q);
      logic hit = 1'b0;
      for (int i = 0; i < 4; i++) if (tok_tab[i] == q) hit = 1'b1;
      return hit;
   endfunction

   // Expected {ctrl_valid, ctrl, terc4_valid, terc4, video_valid, data}.
   function automatic logic [16:0] ref_decode(input logic [9:0] q);
      logic       cv = 1'b0, tv = 1'b0;
      logic [1:0] c  = 2'd0;
      logic [3:0] t  = 4'd0;
      logic [7:0] d  = 8'h00;
      for (int i = 0; i < 4; i++) if (tok_tab[i] == q) begin cv = 1'b1; c = 2'(i); end
      for (int i = 0; i < 16; i++) if (terc_tab[i] == q) begin tv = 1'b1; t = 4'(i); end
      for (int b = 0; b < 256; b++) if (tmds_encode(8'(b), q[8], q[9]) == q) d = 8'(b);
      if (cv) d = 8'h00;
      return {cv, c, tv, t, ~cv, d};
   endfunction

   function automatic logic [9:0] rand_video();
      logic [9:0] v;
      do v = 10'($urandom_range(0, 1023)); while (is_token(v));
      return v;
   endfunction

   typedef struct {
      int          due;
      logic [16:0] exp;
      logic [9:0]  sym;
   } sb_t;
   sb_t sb[$];
   bit  bits_q[$];
   bit  chk_en = 1'b0;
   int  last_tok_cyc = 0;
   int  rel_cyc = 0;

   logic       locked_d = 1'b0;
   logic [3:0] off_d = 4'd0;
   int         rise_cyc = -1, fall_cyc = -1;
   logic [3:0] fall_off = 4'd0, fall_prev_off = 4'd0;
   int         off_cyc[$];
   logic [3:0] off_val[$];
   bit         wrapped = 1'b0, any_lock = 1'b0, hold_phase = 1'b0;
   int         drops = 0;

   // Output monitor: scoreboard pops plus lock/offset event logging.
   always @(negedge clk_pixel) begin
      sb_t         e;
      logic [16:0] got;
      while (sb.size() > 0 && sb[0].due < cyc) begin
         e = sb.pop_front();
         check_eq("sb_missed", cyc, e.due);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e   = sb.pop_front();
         got = {ctrl_valid, ctrl, terc4_valid, terc4, video_valid, data};
         if (!e.exp[16]) got[15:14] = 2'b00;
         if (!e.exp[13]) got[12:9]  = 4'h0;
         check_eq($sformatf("sym_%b", e.sym), {15'd0, got}, {15'd0, e.exp});
      end
      if (!locked_d && locked) rise_cyc = cyc;
      if (locked_d && !locked) begin
         fall_cyc      = cyc;
         fall_off      = bit_offset;
         fall_prev_off = off_d;
      end
      if (bit_offset != off_d) begin
         off_cyc.push_back(cyc);
         off_val.push_back(bit_offset);
         if (off_d == 4'd9 && bit_offset == 4'd0) wrapped = 1'b1;
      end
      if (locked) any_lock = 1'b1;
      if (hold_phase && !locked) drops++;
      locked_d = locked;
      off_d    = bit_offset;
   end

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_locked"}, locked, 0);
      check_eq({tag, "_offset"}, bit_offset, 0);
      check_eq({tag, "_ctrl_valid"}, ctrl_valid, 0);
      check_eq({tag, "_ctrl"}, ctrl, 0);
      check_eq({tag, "_terc4_valid"}, terc4_valid, 0);
      check_eq({tag, "_terc4"}, terc4, 0);
      check_eq({tag, "_video_valid"}, video_valid, 0);
      check_eq({tag, "_data"}, data, 0);
   endtask

   task automatic clear_logs();
      sb.delete();
      bits_q.delete();
      off_cyc.delete();
      off_val.delete();
      wrapped  = 1'b0;
      any_lock = 1'b0;
      rise_cyc = -1;
      fall_cyc = -1;
   endtask

   task automatic do_reset(input string tag, input int delay);
      chk_en  = 1'b0;
      reset   = 1'b1;
      tmds_in = 10'd0;
      repeat (3) @(posedge clk_pixel);
      @(negedge clk_pixel);
      check_reset_vals(tag);
      reset   = 1'b0;
      rel_cyc = cyc;
      clear_logs();
      for (int i = 0; i < delay; i++) bits_q.push_back(1'b0);
   endtask

   // Serialise a symbol; each call completes exactly one word of the stream.
   task automatic send_sym(input logic [9:0] s);
      logic [9:0] w;
      sb_t        e;
      for (int i = 0; i < 10; i++) bits_q.push_back(s[i]);
      while (bits_q.size() >= 10) begin
         for (int i = 0; i < 10; i++) w[i] = bits_q.pop_front();
         @(posedge clk_pixel);
         #1;
         tmds_in = w;
      end
      if (chk_en) begin
         e.due = cyc + 2;
         e.exp = ref_decode(s);
         e.sym = s;
         sb.push_back(e);
      end
      if (is_token(s)) last_tok_cyc = cyc;
   endtask

   task automatic lock_run(input string tag);
      int t0;
      rise_cyc = -1;
      send_sym(T00);
      t0 = cyc;
      repeat (15) send_sym(T00);
      for (int i = 0; i < 12 && !locked; i++) send_sym(T00);
      check_eq({tag, "_locked"}, locked, 1);
      check_eq({tag, "_offset"}, bit_offset, 0);
      check_eq({tag, "_lock_time"}, 32'((rise_cyc >= t0) && (rise_cyc - t0 <= 16 + LOCK_COUNT + 2)), 1);
   endtask

   task automatic mixed_burst();
      chk_en = 1'b1;
      send_sym(V00);
      send_sym(VFF);
      send_sym(T00); send_sym(T01); send_sym(T10); send_sym(T11);
      send_sym(TERC9);
      for (int i = 0; i < 16; i += 5) send_sym(terc_tab[i]);
      for (int i = 0; i < 20; i++) send_sym(rand_video());
      send_sym(T11); send_sym(V00);
      chk_en = 1'b0;
      repeat (3) send_sym(T00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      // Loopback at offset 0 and symbol classification.
      do_reset("rst0", 0);
      lock_run("t1");
      mixed_burst();

      // Video only while locked: timeout exactly DWELL after the last full run.
      repeat (12) send_sym(T00);
      fall_cyc = -1;
      for (int i = 0; i < DWELL + 40 && fall_cyc < 0; i++) send_sym(rand_video());
      check_eq("t4_timeout_cycles", fall_cyc - last_tok_cyc, DWELL + 4);
      check_eq("t4_offset_after", fall_off, 1);
      check_eq("t4_offset_before", fall_prev_off, 0);

      // Periodic control bursts keep lock.
      do_reset("rst1", 0);
      lock_run("hold");
      drops      = 0;
      hold_phase = 1'b1;
      for (int blk = 0; blk < 6; blk++) begin
         repeat (12) send_sym(T00);
         repeat (188) send_sym(rand_video());
      end
      hold_phase = 1'b0;
      check_eq("hold_drops", drops, 0);
      check_eq("hold_locked", locked, 1);

      // Stream delayed by 7 serial bits.
      do_reset("rst2", 7);
      for (int i = 0; i < 12 * DWELL && !locked; i++) send_sym(T00);
      check_eq("t2_locked", locked, 1);
      check_eq("t2_offset", bit_offset, 7);
      check_eq("t2_steps", off_val.size(), 7);
      if (off_val.size() == 7) begin
         for (int i = 0; i < 7; i++) begin
            check_eq($sformatf("t2_step%0d_val", i), off_val[i], i + 1);
            check_eq($sformatf("t2_step%0d_gap", i),
                     off_cyc[i] - ((i == 0) ? rel_cyc : off_cyc[i-1]), DWELL);
         end
      end
      repeat (4) send_sym(T00);
      mixed_burst();
      check_eq("t2_still_locked", locked, 1);

      // Runs one short of LOCK_COUNT never lock; offset wraps.
      do_reset("rst3", 0);
      for (int it = 0; it < 400 && !wrapped; it++) begin
         repeat (LOCK_COUNT - 1) send_sym(T00);
         send_sym(V00);
      end
      check_eq("t5_wrapped", wrapped, 1);
      check_eq("t5_never_locked", any_lock, 0);

      // Asynchronous reset mid-lock, then relock.
      do_reset("rst4", 0);
      lock_run("t6a");
      repeat (5) send_sym(rand_video());
      @(posedge clk_pixel);
      #3;
      reset = 1'b1;
      #1;
      check_reset_vals("t6_async");
      @(posedge clk_pixel);
      @(negedge clk_pixel);
      reset = 1'b0;
      clear_logs();
      lock_run("t6b");
      mixed_burst();

      check_eq("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
